// File: rtl/bin_conv3x3_stream_pkg.sv
// Shared constants and arithmetic helpers for the 3x3 binary convolution stream.
// Tap k = 3*dr + dc, with row 0 / column 0 being the top-left of the window.
package bin_conv_pkg;

   localparam int TAP_N     = 9;
   localparam int BIAS_ADDR = 9;

   localparam int TAP_TL = 0;
   localparam int TAP_TC = 1;
   localparam int TAP_TR = 2;
   localparam int TAP_ML = 3;
   localparam int TAP_MC = 4;
   localparam int TAP_MR = 5;
   localparam int TAP_BL = 6;
   localparam int TAP_BC = 7;
   localparam int TAP_BR = 8;

   // Nine taps plus bias need four extra bits of headroom over one weight.
   function automatic int acc_w(input int w_bits);
      return w_bits + 4;
   endfunction

   function automatic int sat(input int acc, input int out_w);
      int hi;
      int lo;
      hi = (1 << (out_w - 1)) - 1;
      lo = -(1 << (out_w - 1));
      if (acc > hi)
         return hi;
      else if (acc < lo)
         return lo;
      else
         return acc;
   endfunction

endpackage

// File: rtl/bin_conv3x3_stream_if.sv
// Pixel-in / result-out bundle of the 3x3 convolution stage, plus its weight write port.
// master drives pixels and configuration; slave is the convolution block.
interface bin_conv3x3_stream_if #(
   parameter int W_BITS = 8,
   parameter int OUT_W  = 8
);
   logic                     din_valid;
   logic                     din;
   logic                     sof;
   logic                     cfg_we;
   logic [3:0]               cfg_addr;
   logic signed [W_BITS-1:0] cfg_data;
   logic                     dout_valid;
   logic signed [OUT_W-1:0]  dout;
   logic                     dout_last;

   modport master (
      output din_valid, din, sof, cfg_we, cfg_addr, cfg_data,
      input  dout_valid, dout, dout_last
   );

   modport slave (
      input  din_valid, din, sof, cfg_we, cfg_addr, cfg_data,
      output dout_valid, dout, dout_last
   );
endinterface

// File: rtl/bin_conv3x3_stream_line_buffer.sv
// Two-row-plus-three-pixel shift register exposing the 3x3 window ending at the incoming pixel.
// The window includes i_din combinationally so the caller can register it on the accepting edge.
module bin_line_buffer #(
   parameter int IMG_W = 34
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic       i_din,
   output logic [8:0] o_win
);
   localparam int SR_N = 2 * IMG_W + 2;

   logic [SR_N-1:0] r_sr;
   logic [SR_N:0]   w_span;

   // w_span[0] is the pixel being accepted; w_span[2*IMG_W+2] is the oldest one in the window.
   assign w_span = {r_sr, i_din};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sr <= '0;
      else if (i_en)
         r_sr <= w_span[SR_N-1:0];
   end

   for (genvar k = 0; k < 9; k++) begin : g_tap
      assign o_win[k] = w_span[(2 - k / 3) * IMG_W + (2 - k % 3)];
   end

endmodule

// File: rtl/bin_conv3x3_stream.sv
// Streaming 3x3 signed-weight convolution over a 1-bit raster; 2-cycle latency, no backpressure.
// Define BIN_CONV_RELU_EN to clamp negative results to 0.
module bin_conv3x3_stream
   import bin_conv_pkg::*;
#(
   parameter int IMG_W  = 34,
   parameter int IMG_H  = 34,
   parameter int W_BITS = 8,
   parameter int OUT_W  = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   bin_conv3x3_stream_if.slave bus
);
   localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int ACC_W = acc_w(W_BITS);

   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_2   = CW'(2);
   localparam logic [RW-1:0] ROW_2   = RW'(2);

   logic [CW-1:0]             r_col, w_col, w_col_nxt;
   logic [RW-1:0]             r_row, w_row, w_row_nxt;
   logic                      w_complete, w_at_last;
   logic [8:0]                w_win, r_s1_win;
   logic                      r_s1_vld, r_s1_last;
   logic signed [W_BITS-1:0]  r_w [TAP_N];
   logic signed [W_BITS-1:0]  r_bias;
   logic signed [ACC_W-1:0]   w_acc;
   logic signed [OUT_W-1:0]   w_sat, w_res;
   logic                      r_dout_valid, r_dout_last;
   logic signed [OUT_W-1:0]   r_dout;

   bin_line_buffer #(.IMG_W(IMG_W)) u_line_buffer (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (bus.din_valid),
      .i_din (bus.din),
      .o_win (w_win)
   );

   // Position of the pixel being accepted this cycle; sof overrides the running counters.
   always_comb begin
      w_col      = bus.sof ? '0 : r_col;
      w_row      = bus.sof ? '0 : r_row;
      w_complete = (w_row >= ROW_2) && (w_col >= COL_2);
      w_at_last  = (w_row == ROW_MAX) && (w_col == COL_MAX);
      w_col_nxt  = w_col + 1'b1;
      w_row_nxt  = w_row;
      if (w_col == COL_MAX) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row == ROW_MAX) ? '0 : w_row + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_s1_vld  <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_win  <= '0;
      end else begin
         r_s1_vld  <= bus.din_valid & w_complete;
         r_s1_last <= bus.din_valid & w_complete & w_at_last;
         if (bus.din_valid) begin
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_s1_win <= w_win;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAP_N; k++)
            r_w[k] <= '0;
         r_bias <= '0;
      end else if (bus.cfg_we) begin
         if (bus.cfg_addr < 4'(TAP_N))
            r_w[bus.cfg_addr] <= bus.cfg_data;
         else if (bus.cfg_addr == 4'(BIAS_ADDR))
            r_bias <= bus.cfg_data;
      end
   end

   always_comb begin
      w_acc = ACC_W'(r_bias);
      for (int k = 0; k < TAP_N; k++)
         if (r_s1_win[k])
            w_acc = w_acc + ACC_W'(r_w[k]);
   end

   assign w_sat = OUT_W'(sat(int'(w_acc), OUT_W));

`ifdef BIN_CONV_RELU_EN
   assign w_res = w_sat[OUT_W-1] ? '0 : w_sat;
`else
   assign w_res = w_sat;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout_valid <= 1'b0;
         r_dout_last  <= 1'b0;
         r_dout       <= '0;
      end else begin
         r_dout_valid <= r_s1_vld;
         r_dout_last  <= r_s1_last;
         if (r_s1_vld)
            r_dout <= w_res;
      end
   end

   assign bus.dout_valid = r_dout_valid;
   assign bus.dout       = r_dout;
   assign bus.dout_last  = r_dout_last;

endmodule

// File: tb/tb_bin_conv3x3_stream.sv
// Bench for bin_conv3x3_stream on a 5x5 image: random pixels/weights against a direct window-sum model.
module tb_bin_conv3x3_stream;
   localparam int W = 5;
   localparam int H = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bin_conv3x3_stream_if #(.W_BITS(8), .OUT_W(8)) bus ();

   bin_conv3x3_stream #(.IMG_W(W), .IMG_H(H), .W_BITS(8), .OUT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_pulse = 0;
   int held = 0;

   int mw [9];
   int mbias;
   bit img [H][W];
   int mr, mc;
   int exp_val [$];
   bit exp_last [$];
   int exp_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int conv(input int cr, input int cc);
      int acc;
      acc = mbias;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            if (img[cr - 1 + dr][cc - 1 + dc]) acc += mw[3 * dr + dc];
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
`ifdef BIN_CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      return acc;
   endfunction

   // Scoreboard: every pulse must match the oldest expected result, its flag and its cycle.
   always @(negedge clk) begin : mon
      int v, c;
      bit l;
      logic signed [7:0] ev;
      if (!rst_n) begin
         held = 0;
      end else if (bus.dout_valid) begin
         n_pulse++;
         checks++;
         if (exp_val.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d dout=%0d, no output expected", cyc, bus.dout);
         end else begin
            v = exp_val.pop_front(); l = exp_last.pop_front(); c = exp_cyc.pop_front();
            ev = 8'(v);
            held = v;
            if (bus.dout !== ev) begin
               errors++; $display("FAIL dout_value cyc=%0d got=%0d want=%0d", cyc, bus.dout, ev);
            end
            checks++;
            if (bus.dout_last !== l) begin
               errors++; $display("FAIL dout_last cyc=%0d got=%b want=%b", cyc, bus.dout_last, l);
            end
            checks++;
            if (cyc !== c) begin
               errors++; $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, c);
            end
         end
      end else begin
         ev = 8'(held);
         checks++;
         if (bus.dout !== ev || bus.dout_last !== 1'b0) begin
            errors++;
            $display("FAIL hold cyc=%0d dout=%0d last=%b want dout=%0d last=0", cyc, bus.dout, bus.dout_last, ev);
         end
      end
   end

   task automatic drive_pix(input bit d, input bit s, input int gap);
      @(negedge clk);
      bus.din_valid = 1'b1; bus.din = d; bus.sof = s;
      if (s) begin mr = 0; mc = 0; end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
         exp_val.push_back(conv(mr - 1, mc - 1));
         exp_last.push_back(mr == H - 1 && mc == W - 1);
         exp_cyc.push_back(cyc + 2);
      end
      if (mc == W - 1) begin mc = 0; mr = (mr == H - 1) ? 0 : mr + 1; end
      else mc++;
      repeat (gap) begin
         @(negedge clk);
         bus.din_valid = 1'b0; bus.din = 1'($urandom); bus.sof = 1'($urandom);
      end
   endtask

   // kind: 0 all ones, 1 random, 2 single one at (2,2). gmode: 0 none, 1 alternate, 2 random gaps.
   task automatic drive_frame(input int kind, input bit first_sof, input int gmode);
      for (int i = 0; i < W * H; i++) begin
         bit d;
         int g;
         case (kind)
            0: d = 1'b1;
            1: d = 1'($urandom);
            default: d = (i == 2 * W + 2);
         endcase
         g = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
         drive_pix(d, first_sof && (i == 0), g);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.din_valid = 1'b0; bus.sof = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg(input int addr, input int val);
      @(negedge clk);
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'(addr); bus.cfg_data = 8'(val);
      if (addr < 9) mw[addr] = val;
      else if (addr == 9) mbias = val;
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   task automatic set_all(input int w, input int b);
      for (int k = 0; k < 9; k++) cfg(k, w);
      cfg(9, b);
   endtask

   task automatic rand_weights();
      for (int k = 0; k < 10; k++) cfg(k, int'($urandom_range(0, 255)) - 128);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.dout_valid); end
      checks++;
      if (bus.dout !== 8'sd0) begin errors++; $display("FAIL reset_dout got=%0d want=0", bus.dout); end
      checks++;
      if (bus.dout_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b want=0", bus.dout_last); end
      rst_n = 1'b1;
   endtask

   task automatic test_all_ones();
      int p0;
      set_all(1, 0);
      p0 = n_pulse;
      drive_frame(0, 1'b1, 0);
      idle(4);
      checks++;
      if (n_pulse - p0 !== 9) begin errors++; $display("FAIL ones_count got=%0d want=9", n_pulse - p0); end
      checks++;
      if (exp_val.size() !== 0) begin errors++; $display("FAIL ones_pending got=%0d want=0", exp_val.size()); end
   endtask

   task automatic test_single_pixel();
      int p0;
      set_all(0, -3);
      cfg(4, 5);
      p0 = n_pulse;
      drive_frame(2, 1'b1, 0);
      idle(4);
      checks++;
      if (n_pulse - p0 !== 9) begin errors++; $display("FAIL single_count got=%0d want=9", n_pulse - p0); end
   endtask

   task automatic test_saturation();
      int p0;
      set_all(127, 127);
      p0 = n_pulse;
      drive_frame(0, 1'b1, 0);
      idle(3);
      set_all(-128, -128);
      drive_frame(0, 1'b1, 0);
      idle(4);
      checks++;
      if (n_pulse - p0 !== 18) begin errors++; $display("FAIL sat_count got=%0d want=18", n_pulse - p0); end
   endtask

   task automatic test_gaps();
      int p0;
      set_all(1, 0);
      for (int a = 10; a < 16; a++) cfg(a, int'($urandom_range(0, 255)) - 128);
      p0 = n_pulse;
      drive_frame(0, 1'b1, 1);
      idle(3);
      rand_weights();
      drive_frame(1, 1'b1, 2);
      idle(4);
      checks++;
      if (n_pulse - p0 !== 18) begin errors++; $display("FAIL gaps_count got=%0d want=18", n_pulse - p0); end
   endtask

   task automatic test_sof_restart();
      int p0;
      rand_weights();
      p0 = n_pulse;
      for (int i = 0; i < 17; i++) drive_pix(1'($urandom), 1'b0, 0);
      drive_frame(1, 1'b1, 0);
      idle(4);
      checks++;
      if (n_pulse - p0 !== 12) begin errors++; $display("FAIL sof_count got=%0d want=12", n_pulse - p0); end
   endtask

   task automatic test_back_to_back();
      int p0;
      rand_weights();
      p0 = n_pulse;
      drive_frame(1, 1'b1, 0);
      drive_frame(1, 1'b0, 0);
      idle(4);
      checks++;
      if (n_pulse - p0 !== 18) begin errors++; $display("FAIL b2b_count got=%0d want=18", n_pulse - p0); end
   endtask

   task automatic test_reset_midframe();
      int p0;
      set_all(0, 100);
      for (int i = 0; i < 13; i++) drive_pix(1'($urandom), i == 0, 0);
      @(negedge clk);
      bus.din_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b want=0", bus.dout_valid); end
      checks++;
      if (bus.dout !== 8'sd0) begin errors++; $display("FAIL rst_mid_dout got=%0d want=0", bus.dout); end
      exp_val.delete(); exp_last.delete(); exp_cyc.delete();
      for (int k = 0; k < 9; k++) mw[k] = 0;
      mbias = 0; mr = 0; mc = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      p0 = n_pulse;
      drive_frame(1, 1'b0, 0);
      idle(4);
      checks++;
      if (n_pulse - p0 !== 9) begin errors++; $display("FAIL rst_mid_count got=%0d want=9", n_pulse - p0); end
   endtask

   initial begin
      bus.din_valid = 1'b0; bus.din = 1'b0; bus.sof = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_addr = 4'd0; bus.cfg_data = 8'sd0;
      for (int k = 0; k < 9; k++) mw[k] = 0;
      mbias = 0; mr = 0; mc = 0;
      test_reset();
      test_all_ones();
      test_single_pixel();
      test_saturation();
      test_gaps();
      test_sof_restart();
      test_back_to_back();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
